// File: rtl/mix_backward_if.sv
// Bus bundle for mix_backward: run/layer select/dy in, dx/valid out,
// weight read port. master = controller + weight memory, slave = core.
interface mix_backward_if #(
  parameter int HID_DIM    = 16,
  parameter int DATA_N     = 8,
  parameter int N_LEN      = 16,
  parameter int N_LEN_W    = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int STATE_LEN  = 4
);
  logic                        run;
  logic [STATE_LEN-1:0]        state;
  logic [HID_DIM*N_LEN-1:0]    d;
  logic                        valid;
  logic [HID_DIM*N_LEN-1:0]    q;
  logic [ADDR_WIDTH-1:0]       raddr_w;
  logic [DATA_N*N_LEN_W-1:0]   rdata_w;

  modport master (
    output run, state, d, rdata_w,
    input  valid, q, raddr_w
  );

  modport slave (
    input  run, state, d, rdata_w,
    output valid, q, raddr_w
  );
endinterface

// File: rtl/mix_backward.sv
// Mixer backward pass: dx = W^T * dy, weights streamed one word per cycle.
// Ports: clk, rst (sync, active-high), bus (run/state/d/rdata_w in; valid/q/raddr_w out).
`ifndef STATE_LEN
`define STATE_LEN 4
`endif
`ifndef B_MIX1
`define B_MIX1 4'd4
`endif
`ifndef B_MIX2
`define B_MIX2 4'd5
`endif
`ifndef B_MIX3
`define B_MIX3 4'd6
`endif

module mix_backward #(
  parameter int HID_DIM    = 16,
  parameter int DATA_N     = 8,
  parameter int N_LEN      = 16,
  parameter int N_LEN_W    = 8,
  parameter int W_FRAC     = 6,
  parameter int ADDR_WIDTH = 9,
  parameter int STATE_LEN  = `STATE_LEN
) (
  input  logic          clk,
  input  logic          rst,
  mix_backward_if.slave bus
);
  localparam int WORDS = HID_DIM * HID_DIM / DATA_N;
  localparam int CNT_W = $clog2(WORDS);
  localparam int P_W   = N_LEN + N_LEN_W;
  localparam int ACC_W = N_LEN + 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-N_LEN+1){1'b0}}, {(N_LEN-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV =
    {{(ACC_W-N_LEN+1){1'b1}}, {(N_LEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } st_e;

  st_e                       st_q, st_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]     base_q, base_d;
  logic [ADDR_WIDTH-1:0]     raddr_q, raddr_d;
  logic signed [N_LEN-1:0]   dy_q [HID_DIM];
  logic signed [N_LEN-1:0]   dy_d [HID_DIM];
  logic signed [ACC_W-1:0]   acc_q [HID_DIM];
  logic signed [ACC_W-1:0]   acc_d [HID_DIM];
  logic signed [ACC_W-1:0]   acc_sum [HID_DIM];
  logic [HID_DIM*N_LEN-1:0]  q_q, q_d;
  logic                      valid_q, valid_d;

  logic [CNT_W-1:0]          widx;
  logic                      acc_en;
  logic signed [N_LEN-1:0]   dy_sel;
  logic signed [P_W-1:0]     prod [DATA_N];
  logic signed [ACC_W-1:0]   term [DATA_N];

  function automatic logic [ADDR_WIDTH-1:0] bank_base(
    input logic [STATE_LEN-1:0] s
  );
    bank_base = '0;
    unique case (1'b1)
      (s == STATE_LEN'(`B_MIX1)): bank_base = '0;
      (s == STATE_LEN'(`B_MIX2)): bank_base = ADDR_WIDTH'(WORDS);
      (s == STATE_LEN'(`B_MIX3)): bank_base = ADDR_WIDTH'(2 * WORDS);
      default: bank_base = '0;
    endcase
  endfunction

  function automatic logic [N_LEN-1:0] sat(
    input logic signed [ACC_W-1:0] a
  );
    if (a > MAXV)      sat = MAXV[N_LEN-1:0];
    else if (a < MINV) sat = MINV[N_LEN-1:0];
    else               sat = a[N_LEN-1:0];
  endfunction

  // rdata_w lags the address by one cycle: while READ shows cnt=c the
  // word on the bus is c-1; DRAIN sees the final word.
  assign widx   = (st_q == DRAIN) ? LAST : cnt_q - CNT_W'(1);
  assign acc_en = (st_q == READ && cnt_q != '0) || st_q == DRAIN;

  always_comb begin
    dy_sel = dy_q[widx[CNT_W-1:1]];
    for (int n = 0; n < DATA_N; n++) begin
      prod[n] = $signed(bus.rdata_w[n*N_LEN_W +: N_LEN_W]) * dy_sel;
      term[n] = ACC_W'(prod[n] >>> W_FRAC);
    end
  end

  // Odd words feed the upper half of dx, even words the lower half.
  always_comb begin
    for (int j = 0; j < HID_DIM; j++) begin
      acc_sum[j] = acc_q[j];
      if (acc_en && widx[0] == 1'(j / DATA_N))
        acc_sum[j] = acc_q[j] + term[j % DATA_N];
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    raddr_d = raddr_q;
    dy_d    = dy_q;
    acc_d   = acc_q;
    q_d     = q_q;
    valid_d = 1'b0;
    if (!bus.run) begin
      st_d    = IDLE;
      cnt_d   = '0;
      raddr_d = bank_base(bus.state);
      for (int j = 0; j < HID_DIM; j++) acc_d[j] = '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          st_d    = READ;
          cnt_d   = '0;
          base_d  = bank_base(bus.state);
          raddr_d = bank_base(bus.state);
          for (int j = 0; j < HID_DIM; j++) begin
            acc_d[j] = '0;
            dy_d[j]  = bus.d[j*N_LEN +: N_LEN];
          end
        end
        READ: begin
          acc_d = acc_sum;
          if (cnt_q == LAST) begin
            st_d = DRAIN;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            raddr_d = base_q + ADDR_WIDTH'(cnt_q) + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          acc_d   = acc_sum;
          st_d    = DONE;
          valid_d = 1'b1;
          for (int j = 0; j < HID_DIM; j++)
            q_d[j*N_LEN +: N_LEN] = sat(acc_sum[j]);
        end
        DONE: begin
          valid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      raddr_q <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      for (int j = 0; j < HID_DIM; j++) begin
        dy_q[j]  <= '0;
        acc_q[j] <= '0;
      end
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      raddr_q <= raddr_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      for (int j = 0; j < HID_DIM; j++) begin
        dy_q[j]  <= dy_d[j];
        acc_q[j] <= acc_d[j];
      end
    end
  end

  assign bus.valid   = valid_q;
  assign bus.q       = q_q;
  assign bus.raddr_w = raddr_q;

endmodule
